// File: rtl/datapath_pkg.sv
// Shared encodings for the CDECV datapath: bus X source codes, write-enable
// bit indices, ALU function codes and flag register bit positions.
package datapath_pkg;

  typedef enum logic [2:0] {
    XS_PC  = 3'd0,
    XS_A   = 3'd1,
    XS_B   = 3'd2,
    XS_C   = 3'd3,
    XS_RD  = 3'd4,
    XS_R   = 3'd5,
    XS_FLG = 3'd6,
    XS_FF  = 3'd7
  } xsrc_e;

  localparam int unsigned XD_PC  = 0;
  localparam int unsigned XD_A   = 1;
  localparam int unsigned XD_B   = 2;
  localparam int unsigned XD_C   = 3;
  localparam int unsigned XD_MA  = 4;
  localparam int unsigned XD_WD  = 5;
  localparam int unsigned XD_I   = 6;
  localparam int unsigned XD_T   = 7;
  localparam int unsigned XD_R   = 8;
  localparam int unsigned XD_FLG = 9;

  typedef enum logic [3:0] {
    OP_THRU = 4'd0,
    OP_ADD  = 4'd1,
    OP_ADC  = 4'd2,
    OP_SUB  = 4'd3,
    OP_SBB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_EOR  = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_NOT  = 4'd10
  } aluop_e;

  localparam int unsigned FLG_CY = 0;
  localparam int unsigned FLG_Z  = 1;
  localparam int unsigned FLG_S  = 2;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: operands X, T and the current carry; 9-bit internal
// arithmetic whose bit 8 is carry-out for additions and borrow for subtractions.
module alu
  import datapath_pkg::*;
(
  input  logic [7:0] x_i,
  input  logic [7:0] t_i,
  input  logic       cy_i,
  input  logic [3:0] aluop_i,
  output logic [7:0] y_o,
  output logic       s_o,
  output logic       z_o,
  output logic       cy_o
);

  logic [8:0] res;
  logic [8:0] x9;
  logic [8:0] t9;
  logic [8:0] c9;

  assign x9 = {1'b0, x_i};
  assign t9 = {1'b0, t_i};
  assign c9 = {8'b0, cy_i};

  // Function select; logic/pass-through results keep bit 8 clear so Cy=0.
  always_comb begin
    res = {1'b0, x_i};
    case (aluop_i)
      OP_ADD:  res = x9 + t9;
      OP_ADC:  res = x9 + t9 + c9;
      OP_SUB:  res = x9 - t9;
      OP_SBB:  res = x9 - t9 - c9;
      OP_AND:  res = {1'b0, x_i & t_i};
      OP_OR:   res = {1'b0, x_i | t_i};
      OP_EOR:  res = {1'b0, x_i ^ t_i};
      OP_INC:  res = x9 + 9'd1;
      OP_DEC:  res = x9 - 9'd1;
      OP_NOT:  res = {1'b0, ~x_i};
      default: res = {1'b0, x_i};
    endcase
  end

  assign y_o  = res[7:0];
  assign s_o  = res[7];
  assign z_o  = (res[7:0] == 8'h00);
  assign cy_o = res[8];

endmodule

// File: rtl/datapath.sv
// CDECV 8-bit datapath: register file, bus X source mux, ALU, flag register
// and memory-side registers. Optional monitor taps under CDECV_MONITOR_EN.
module datapath
  import datapath_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] xsrc,
  input  logic [9:0] xdst,
  input  logic [3:0] aluop,
  input  logic [7:0] rd,
  output logic [7:0] ma,
  output logic [7:0] wd,
  output logic [7:0] I,
  output logic [2:0] SZCy
`ifdef CDECV_MONITOR_EN
  ,
  output logic [7:0] mon_pc,
  output logic [7:0] mon_a,
  output logic [7:0] mon_b,
  output logic [7:0] mon_c
`endif
);

  logic [7:0] pc_q, a_q, b_q, c_q, t_q, i_q, ma_q, wd_q, r_q;
  logic [7:0] pc_d, a_d, b_d, c_d, t_d, i_d, ma_d, wd_d, r_d;
  logic [2:0] flg_q, flg_d;
  logic [7:0] x;
  logic [7:0] y;
  logic       s, z, cy;

  // Bus X source select; RD passes straight through from RAM.
  always_comb begin
    x = 8'hFF;
    case (xsrc)
      XS_PC:   x = pc_q;
      XS_A:    x = a_q;
      XS_B:    x = b_q;
      XS_C:    x = c_q;
      XS_RD:   x = rd;
      XS_R:    x = r_q;
      XS_FLG:  x = {5'b0, flg_q};
      default: x = 8'hFF;
    endcase
  end

  alu u_alu (
    .x_i     (x),
    .t_i     (t_q),
    .cy_i    (flg_q[FLG_CY]),
    .aluop_i (aluop),
    .y_o     (y),
    .s_o     (s),
    .z_o     (z),
    .cy_o    (cy)
  );

  // Next-state per register: load from X (or ALU for R/FLG) when enabled.
  always_comb begin
    pc_d  = xdst[XD_PC]  ? x : pc_q;
    a_d   = xdst[XD_A]   ? x : a_q;
    b_d   = xdst[XD_B]   ? x : b_q;
    c_d   = xdst[XD_C]   ? x : c_q;
    ma_d  = xdst[XD_MA]  ? x : ma_q;
    wd_d  = xdst[XD_WD]  ? x : wd_q;
    i_d   = xdst[XD_I]   ? x : i_q;
    t_d   = xdst[XD_T]   ? x : t_q;
    r_d   = xdst[XD_R]   ? y : r_q;
    flg_d = xdst[XD_FLG] ? {s, z, cy} : flg_q;
  end

  // Register bank update; reset clears everything and overrides any load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      ma_q  <= '0;
      wd_q  <= '0;
      i_q   <= '0;
      t_q   <= '0;
      r_q   <= '0;
      flg_q <= '0;
    end else begin
      pc_q  <= pc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      ma_q  <= ma_d;
      wd_q  <= wd_d;
      i_q   <= i_d;
      t_q   <= t_d;
      r_q   <= r_d;
      flg_q <= flg_d;
    end
  end

  assign ma   = ma_q;
  assign wd   = wd_q;
  assign I    = i_q;
  assign SZCy = flg_q;

`ifdef CDECV_MONITOR_EN
  assign mon_pc = pc_q;
  assign mon_a  = a_q;
  assign mon_b  = b_q;
  assign mon_c  = c_q;
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the CDECV datapath.
module tb_datapath;
  import datapath_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] xsrc  = 3'd0;
  logic [9:0] xdst  = 10'd0;
  logic [3:0] aluop = 4'd0;
  logic [7:0] rd    = 8'd0;
  logic [7:0] ma, wd, I;
  logic [2:0] SZCy;
`ifdef CDECV_MONITOR_EN
  logic [7:0] mon_pc, mon_a, mon_b, mon_c;
`endif

  int checks = 0;
  int errs   = 0;

  localparam logic [9:0] D_PC  = 10'b00_0000_0001;
  localparam logic [9:0] D_A   = 10'b00_0000_0010;
  localparam logic [9:0] D_B   = 10'b00_0000_0100;
  localparam logic [9:0] D_C   = 10'b00_0000_1000;
  localparam logic [9:0] D_MA  = 10'b00_0001_0000;
  localparam logic [9:0] D_WD  = 10'b00_0010_0000;
  localparam logic [9:0] D_I   = 10'b00_0100_0000;
  localparam logic [9:0] D_T   = 10'b00_1000_0000;
  localparam logic [9:0] D_R   = 10'b01_0000_0000;
  localparam logic [9:0] D_FLG = 10'b10_0000_0000;

  datapath dut (
    .clock (clock),
    .reset (reset),
    .xsrc  (xsrc),
    .xdst  (xdst),
    .aluop (aluop),
    .rd    (rd),
    .ma    (ma),
    .wd    (wd),
    .I     (I),
    .SZCy  (SZCy)
`ifdef CDECV_MONITOR_EN
    ,
    .mon_pc (mon_pc),
    .mon_a  (mon_a),
    .mon_b  (mon_b),
    .mon_c  (mon_c)
`endif
  );

  always #5 clock = ~clock;

  // Drive one transfer after the negedge, then settle past the posedge.
  task automatic step(input logic [2:0] s, input logic [9:0] d, input logic [3:0] op);
    @(negedge clock);
    xsrc  = s;
    xdst  = d;
    aluop = op;
    @(posedge clock);
    #1;
    xdst = 10'd0;
  endtask

  task automatic load_rd(input logic [7:0] v, input logic [9:0] d);
    rd = v;
    step(XS_RD, d, OP_THRU);
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  initial begin
    // Reset with all loads requested
    @(negedge clock);
    reset = 1'b1;
    xsrc  = XS_FF;
    xdst  = 10'($urandom) | D_MA | D_WD | D_I | D_FLG;
    aluop = OP_NOT;
    @(posedge clock);
    #1;
    chk8("rst_ma", ma, 8'h00);
    chk8("rst_wd", wd, 8'h00);
    chk8("rst_I", I, 8'h00);
    chk3("rst_flg", SZCy, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    xdst  = 10'd0;

    // First load after release
    step(XS_FF, D_A, OP_THRU);
    step(XS_A, D_MA, OP_THRU);
    chk8("ff_to_a", ma, 8'hFF);

    // ADD with carry, then ADC
    load_rd(8'hF0, D_A);
    load_rd(8'h20, D_T);
    step(XS_A, D_R | D_FLG, OP_ADD);
    chk3("add_flg", SZCy, 3'b001);
    step(XS_R, D_MA, OP_THRU);
    chk8("add_r", ma, 8'h10);
    step(XS_A, D_R | D_FLG, OP_ADC);
    chk3("adc_flg", SZCy, 3'b001);
    step(XS_R, D_MA, OP_THRU);
    chk8("adc_r", ma, 8'h11);

    // SUB zero, then borrow
    load_rd(8'h05, D_A | D_T);
    step(XS_A, D_R | D_FLG, OP_SUB);
    chk3("sub0_flg", SZCy, 3'b010);
    step(XS_R, D_MA, OP_THRU);
    chk8("sub0_r", ma, 8'h00);
    load_rd(8'h06, D_T);
    step(XS_A, D_R | D_FLG, OP_SUB);
    chk3("subb_flg", SZCy, 3'b101);
    step(XS_R, D_MA, OP_THRU);
    chk8("subb_r", ma, 8'hFF);

    // Simultaneous destinations
    load_rd(8'h7F, D_PC);
    step(XS_PC, D_MA | D_R | D_FLG, OP_INC);
    chk8("multi_ma", ma, 8'h7F);
    chk3("multi_flg", SZCy, 3'b100);
    step(XS_R, D_WD, OP_THRU);
    chk8("multi_r", wd, 8'h80);

    // Memory path
    load_rd(8'h3C, D_B);
    step(XS_B, D_WD, OP_THRU);
    chk8("wd_b", wd, 8'h3C);
    rd = 8'hA5;
    step(XS_RD, D_I | D_C, OP_THRU);
    chk8("rd_I", I, 8'hA5);
    step(XS_C, D_MA, OP_THRU);
    chk8("rd_c", ma, 8'hA5);

    // Hold: no destination, toggling source/op
    for (int k = 0; k < 10; k++) begin
      step(3'($urandom_range(0, 7)), 10'd0, 4'($urandom_range(0, 15)));
      chk8("hold_ma", ma, 8'hA5);
      chk8("hold_wd", wd, 8'h3C);
      chk8("hold_I", I, 8'hA5);
      chk3("hold_flg", SZCy, 3'b100);
    end

    // Self-update A <- A+1 via R; FLG untouched
    step(XS_A, D_R, OP_INC);
    step(XS_R, D_A, OP_THRU);
    step(XS_A, D_MA, OP_THRU);
    chk8("inc_a", ma, 8'h06);
    chk3("inc_noflg", SZCy, 3'b100);

    // SUB/SBB borrow chain, FLG source, EOR, NOT
    load_rd(8'h00, D_A);
    step(XS_A, D_R | D_FLG, OP_SUB);
    chk3("sub_neg_flg", SZCy, 3'b101);
    step(XS_A, D_R | D_FLG, OP_SBB);
    chk3("sbb_flg", SZCy, 3'b101);
    step(XS_R, D_MA, OP_THRU);
    chk8("sbb_r", ma, 8'hF9);
    step(XS_FLG, D_MA, OP_THRU);
    chk8("flg_src", ma, 8'h05);
    step(XS_A, D_R | D_FLG, OP_EOR);
    chk3("eor_flg", SZCy, 3'b000);
    step(XS_R, D_MA, OP_THRU);
    chk8("eor_r", ma, 8'h06);
    step(XS_A, D_R | D_FLG, OP_NOT);
    chk3("not_flg", SZCy, 3'b100);
    step(XS_R, D_WD, OP_THRU);
    chk8("not_r", wd, 8'hFF);

    // Mid-cycle asynchronous reset overrides a pending load
    @(negedge clock);
    xsrc = XS_FF;
    xdst = D_MA | D_WD | D_FLG;
    aluop = OP_INC;
    #2;
    reset = 1'b1;
    #1;
    chk8("arst_ma", ma, 8'h00);
    chk8("arst_wd", wd, 8'h00);
    @(posedge clock);
    #1;
    chk8("arst_ma_edge", ma, 8'h00);
    chk3("arst_flg", SZCy, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    xdst = 10'd0;
    step(XS_FF, D_MA, OP_THRU);
    chk8("post_rst_load", ma, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errs);
    $finish;
  end

endmodule
